insn_loader: RTL and testbench

Hardware program loader: the write side of the core's instruction memory. It accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words sequentially into instruction memory from word address 0 and holds the core in reset until a complete, checksum-verified image is in place. It replaces backdoor memory initialisation for on-target and system-level runs.

---
 rtl/insn_loader.sv | 172 +++++++++++++++++
 tb/tb_insn_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/insn_loader.sv
// Program loader: receives a length-prefixed, XOR-checked byte stream, assembles
// little-endian 32-bit words into instruction memory and releases the core when the image is good.
module insn_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

  state_t                r_state;
  logic                  r_in_ready;
  logic                  r_busy;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_core_reset;
  logic                  r_done;
  logic                  r_error;
  logic [ADDR_WIDTH:0]   r_word_count;
  logic [ADDR_WIDTH:0]   r_len;
  logic [7:0]            r_len_lo;
  logic [7:0]            r_xor;
  logic [1:0]            r_byte_cnt;
  logic [23:0]           r_shift;

  logic                  w_fire;
  logic [16:0]           w_len_full;
  logic [ADDR_WIDTH:0]   w_wc_inc;
  logic [31:0]           w_word;

  assign w_fire     = in_valid && r_in_ready;
  assign w_len_full = {1'b0, in_data, r_len_lo};
  assign w_wc_inc   = r_word_count + 1'b1;
  // Bytes arrive LSB first, so the newest byte lands in the top lane.
  assign w_word     = {in_data, r_shift};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_reset <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_word_count <= '0;
      r_len        <= '0;
      r_len_lo     <= '0;
      r_xor        <= '0;
      r_byte_cnt   <= '0;
      r_shift      <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (load_start) begin
            r_state      <= S_LEN0;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b1;
            r_mem_addr   <= '0;
            r_word_count <= '0;
            r_xor        <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_core_reset <= 1'b0;
            r_byte_cnt   <= '0;
          end
        end

        S_LEN0: begin
          if (w_fire) begin
            r_len_lo <= in_data;
            r_xor    <= r_xor ^ in_data;
            r_state  <= S_LEN1;
          end
        end

        S_LEN1: begin
          if (w_fire) begin
            r_xor <= r_xor ^ in_data;
            r_len <= w_len_full[ADDR_WIDTH:0];
            if (w_len_full > DEPTH) begin
              r_state    <= S_ERROR;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_error    <= 1'b1;
            end else if (w_len_full == 17'd0) begin
              r_state <= S_CHECK;
            end else begin
              r_state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (w_fire) begin
            r_xor      <= r_xor ^ in_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= {in_data, r_shift[23:8]};
            if (r_byte_cnt == 2'd3) begin
              r_mem_we     <= 1'b1;
              r_mem_addr   <= r_word_count[ADDR_WIDTH-1:0];
              r_mem_wdata  <= w_word;
              r_word_count <= w_wc_inc;
              if (w_wc_inc == r_len) begin
                r_state <= S_CHECK;
              end
            end
          end
        end

        S_CHECK: begin
          if (w_fire) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            if (in_data == r_xor) begin
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_core_reset <= 1'b1;
            end else begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign core_reset = r_core_reset;
  assign done       = r_done;
  assign error      = r_error;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_insn_loader.sv
// Scoreboard bench for insn_loader: expected writes are queued by the stimulus
// and popped by an independent monitor whenever mem_we is seen.
module tb_insn_loader;

  localparam int AW = 10;

  logic          clk;
  logic          reset;
  logic          load_start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_reset;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [AW:0]   wc;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  insn_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data || word_count !== e.wc) begin
          errors++;
          $display("FAIL write: got addr %h data %h wc %0d expected addr %h data %h wc %0d",
                   mem_addr, mem_wdata, word_count, e.addr, e.data, e.wc);
        end else begin
          $display("ok   write: addr %h data %h wc %0d", mem_addr, mem_wdata, word_count);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready %b expected 1", in_ready);
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic start_frame();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ready", 32'(in_ready), 32'd1);
    chk("start_wc", 32'(word_count), 32'd0);
    chk("start_core_reset", 32'(core_reset), 32'd0);
    chk("start_done_error", {30'd0, done, error}, 32'd0);
  endtask

  task automatic push_good_words();
    exp_q.push_back('{addr: 10'd0, data: 32'hFFE08093, wc: 11'd1});
    exp_q.push_back('{addr: 10'd1, data: 32'hFFD0A113, wc: 11'd2});
  endtask

  task automatic drain(input string name);
    repeat (3) tick();
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  logic [7:0] good_frame [11];

  initial begin
    good_frame = '{8'h02, 8'h00, 8'h93, 8'h80, 8'hE0, 8'hFF, 8'h13, 8'hA1, 8'hD0, 8'hFF, 8'h93};
    reset      = 1'b0;
    load_start = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    repeat (3) tick();
    chk("rst_flags", {25'd0, in_ready, mem_we, busy, done, error, core_reset, 1'b0}, 32'd0);
    chk("rst_addr_data", 32'(mem_addr) | mem_wdata, 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    reset = 1'b1;
    tick();

    // Good 2-word load
    start_frame();
    push_good_words();
    for (int i = 0; i < 10; i++) send_byte(good_frame[i]);
    chk("good_pre_chk_core_reset", 32'(core_reset), 32'd0);
    send_byte(good_frame[10]);
    chk("good_done", 32'(done), 32'd1);
    chk("good_error", 32'(error), 32'd0);
    chk("good_core_reset", 32'(core_reset), 32'd1);
    chk("good_wc", 32'(word_count), 32'd2);
    chk("good_ready_low", 32'(in_ready), 32'd0);
    drain("good_drain");
    chk("good_done_hold", 32'(done), 32'd1);

    // Bad checksum
    start_frame();
    push_good_words();
    for (int i = 0; i < 10; i++) send_byte(good_frame[i]);
    send_byte(8'h92);
    chk("bad_error", 32'(error), 32'd1);
    chk("bad_done", 32'(done), 32'd0);
    chk("bad_core_reset", 32'(core_reset), 32'd0);
    chk("bad_wc", 32'(word_count), 32'd2);
    drain("bad_drain");
    chk("bad_error_hold", 32'(error), 32'd1);

    // Oversize length (N = 1025)
    start_frame();
    send_byte(8'h01);
    send_byte(8'h04);
    chk("over_error", 32'(error), 32'd1);
    chk("over_ready", 32'(in_ready), 32'd0);
    chk("over_busy", 32'(busy), 32'd0);
    chk("over_core_reset", 32'(core_reset), 32'd0);
    drain("over_drain");

    // Exactly-maximum length is accepted into DATA (N = 1024)
    start_frame();
    send_byte(8'h00);
    send_byte(8'h04);
    chk("max_len_ready", 32'(in_ready), 32'd1);
    chk("max_len_error", 32'(error), 32'd0);

    // Reset mid-frame abandons it; restart from IDLE with zero length
    reset = 1'b0;
    tick();
    reset = 1'b1;
    start_frame();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_wc", 32'(word_count), 32'd0);
    chk("zero_core_reset", 32'(core_reset), 32'd1);
    drain("zero_drain");

    // Stalls and an ignored restart during DATA
    start_frame();
    push_good_words();
    for (int i = 0; i < 11; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      if (i == 5) begin
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
      end
      send_byte(good_frame[i]);
    end
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_wc", 32'(word_count), 32'd2);
    chk("stall_core_reset", 32'(core_reset), 32'd1);
    drain("stall_drain");

    // Mid-frame reset after 6 bytes (word 0 completes on the 6th), then partial word 1
    start_frame();
    exp_q.push_back('{addr: 10'd0, data: 32'hFFE08093, wc: 11'd1});
    for (int i = 0; i < 7; i++) send_byte(good_frame[i]);
    reset = 1'b0;
    tick();
    chk("mrst_flags", {25'd0, in_ready, mem_we, busy, done, error, core_reset, 1'b0}, 32'd0);
    chk("mrst_addr_data", 32'(mem_addr) | mem_wdata, 32'd0);
    chk("mrst_wc", 32'(word_count), 32'd0);
    tick();
    reset = 1'b1;
    drain("mrst_drain");
    start_frame();
    push_good_words();
    for (int i = 0; i < 11; i++) send_byte(good_frame[i]);
    chk("resend_done", 32'(done), 32'd1);
    chk("resend_wc", 32'(word_count), 32'd2);
    chk("resend_core_reset", 32'(core_reset), 32'd1);
    drain("resend_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
